pwm_audio_out: RTL and testbench

PWM_AUDIO_OUT -- requirements
Module: pwm_audio_out

---
 rtl/pwm_audio_out.sv | 168 ++++++++++++++++
 tb/tb_pwm_audio_out.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_audio_out.sv
// -----------------------------------------------------------------------------
// pwm_audio_out
//
// Turns 8-bit unsigned audio samples from an upstream mixer into a 1-bit
// bitstream for an external speaker filter. One output period is 256 clock
// cycles. The sample is fetched once per period and played back in the
// following period.
//
// Sequencing:
//   IDLE  : cnt and duty are held at 0. Seeing run=1 at a clock edge moves
//           the block to PRIME, with cnt=0 in the next cycle.
//   PRIME : first period after start. Asks the mixer for a sample but has
//           nothing to play yet, so pwm_out stays low.
//   RUN   : plays the duty latched at the end of the previous period.
//   At the edge that ends cnt==255, the sample is latched into duty and
//   sample_stb pulses in the next cycle. If run is low at that edge, the
//   block returns to IDLE and clears duty instead. Dropping run mid-period
//   never cuts the current period short.
//
// Ports:
//   clk        in   system clock (10 MHz)
//   nrst       in   asynchronous active-low reset
//   run        in   level request to play audio
//   sample     in   [7:0] unsigned mixed sample; must be stable at cnt==255
//   mix_en     out  one-cycle strobe (cnt==0 while PRIME/RUN) asking the
//                   mixer to compute the next sample
//   pwm_out    out  audio bitstream
//   busy       out  high whenever the state is not IDLE
//   sample_stb out  one-cycle pulse in the cycle after a sample is latched
//   fsm_state  out  [1:0] current state (0=IDLE, 1=PRIME, 2=RUN), for debug
//
// Configuration macro:
//   PWM_DELTASIGMA_EN  undefined -> classic PWM: pwm_out = RUN && cnt < duty.
//                      defined   -> first-order delta-sigma modulator. A
//                      9-bit accumulator adds duty every RUN cycle; its
//                      carry bit drives pwm_out, so a period carries exactly
//                      duty high cycles, spread as evenly as possible.
//                      Sequencing, strobes, busy and latency do not change.
//
// Handshake with the mixer: mix_en is a request-only strobe (no ready).
// The mixer has until the cycle with cnt==255 to present a stable sample;
// only the value present in that cycle is taken. Changes on sample at any
// other time have no effect on the period being played.
// -----------------------------------------------------------------------------
module pwm_audio_out (
  input  logic       clk,
  input  logic       nrst,
  input  logic       run,
  input  logic [7:0] sample,
  output logic       mix_en,
  output logic       pwm_out,
  output logic       busy,
  output logic       sample_stb,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic [7:0] duty;
  logic [7:0] duty_next;
  logic       stb_next;
  logic       active;

  // PRIME and RUN behave identically for sequencing; they differ only in
  // whether the modulator is allowed to drive pwm_out.
  assign active = (state == PRIME) || (state == RUN);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      duty       <= 8'd0;
      sample_stb <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      duty       <= duty_next;
      sample_stb <= stb_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    duty_next  = duty;
    stb_next   = 1'b0;

    case (state)
      IDLE: begin
        cnt_next  = 8'd0;
        duty_next = 8'd0;
        if (run) begin
          state_next = PRIME;
        end
      end

      PRIME, RUN: begin
        // 8-bit counter wraps 255 -> 0 naturally, giving a 256-cycle period.
        cnt_next = cnt + 8'd1;
        if (cnt == 8'hFF) begin
          // Period boundary: the only point where sample is looked at and
          // the only point where run is acted upon.
          stb_next = 1'b1;
          if (run) begin
            duty_next  = sample;
            state_next = RUN;
          end else begin
            duty_next  = 8'd0;
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
        duty_next  = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from registers only
  // ---------------------------------------------------------------------------
  assign mix_en    = active && (cnt == 8'd0);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

`ifdef PWM_DELTASIGMA_EN
  // Delta-sigma modulator. acc[7:0] is the running residue, acc[8] the
  // carry of the last addition. Because 256 * duty is a multiple of 256,
  // the residue returns to 0 at every period boundary, so each period with
  // a steady duty produces exactly duty carries. Clearing outside RUN keeps
  // every playback run starting from the same phase.
  logic [8:0] acc;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc <= 9'd0;
    end else if (state == RUN) begin
      acc <= {1'b0, acc[7:0]} + {1'b0, duty};
    end else begin
      acc <= 9'd0;
    end
  end

  assign pwm_out = (state == RUN) && acc[8];
`else
  // Classic PWM: high for the first duty cycles of each RUN period.
  // duty=255 gives 255 of 256 cycles high; duty=0 never goes high.
  assign pwm_out = (state == RUN) && (cnt < duty);
`endif

endmodule

// File: tb/tb_pwm_audio_out.sv
// -----------------------------------------------------------------------------
// tb_pwm_audio_out
//
// Directed bench for pwm_audio_out. Inputs are driven just after the falling
// edge and outputs are sampled on the falling edge, half a cycle away from
// the active rising edge. Each 256-cycle period is walked cycle by cycle;
// the expected number of high cycles per period is hand-computed from the
// sample latched at the end of the previous period.
// -----------------------------------------------------------------------------
module tb_pwm_audio_out;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       nrst;
  logic       run;
  logic [7:0] sample;
  logic       mix_en;
  logic       pwm_out;
  logic       busy;
  logic       sample_stb;
  logic [1:0] fsm_state;

  int n_checks;
  int n_bad;

`ifdef PWM_DELTASIGMA_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  initial clk = 1'b0;
  always #50 clk = ~clk;

  pwm_audio_out dut (
    .clk        (clk),
    .nrst       (nrst),
    .run        (run),
    .sample     (sample),
    .mix_en     (mix_en),
    .pwm_out    (pwm_out),
    .busy       (busy),
    .sample_stb (sample_stb),
    .fsm_state  (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mix_en"}, {31'd0, mix_en}, 32'd0);
    check({tag, "_pwm"},    {31'd0, pwm_out}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy}, 32'd0);
    check({tag, "_stb"},    {31'd0, sample_stb}, 32'd0);
    check({tag, "_state"},  {30'd0, fsm_state}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: walk one full period starting at the falling edge of its cnt==0
  // cycle; returns at the falling edge of the next period's cnt==0 cycle.
  // act_kind: 0 none, 1 set sample to act_val, 2 drop run. The action is
  // applied after observing cycle act_at, so the DUT sees it at the edge
  // ending that cycle.
  // ---------------------------------------------------------------------------
  task automatic run_period(input string tag, input int exp_duty, input int exp_highs,
                            input bit exp_stb, input int act_at, input int act_kind,
                            input logic [7:0] act_val);
    int highs;
    int mixes;
    int mix_off;
    int stbs;
    int stb_first;
    int pat_err;
    int busy_low;
    highs = 0; mixes = 0; mix_off = 0; stbs = 0; stb_first = 0; pat_err = 0; busy_low = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_out) highs++;
      if (mix_en) begin
        mixes++;
        if (i != 0) mix_off++;
      end
      if (sample_stb) begin
        stbs++;
        if (i == 0) stb_first = 1;
      end
      if (!DS && (pwm_out !== (i < exp_duty))) pat_err++;
      if (!busy) busy_low++;
      if (i == act_at) begin
        if (act_kind == 1) sample = act_val;
        if (act_kind == 2) run = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_highs"},    highs, exp_highs);
    check({tag, "_mix_cnt"},  mixes, 1);
    check({tag, "_mix_off"},  mix_off, 0);
    check({tag, "_stb_cnt"},  stbs, exp_stb ? 1 : 0);
    check({tag, "_stb_pos"},  stb_first, exp_stb ? 1 : 0);
    if (!DS) check({tag, "_pattern"}, pat_err, 0);
    check({tag, "_busy_low"}, busy_low, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int mix_seen;
    int busy_seen;
    n_checks = 0;
    n_bad    = 0;
    nrst     = 1'b0;
    run      = 1'b1;
    sample   = 8'd0;

    // Reset held for 2 cycles with run high: everything stays low.
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Release with run low: must remain idle until run is seen.
    nrst = 1'b1;
    run  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("post_reset_idle");

    // Start playback; the next cycle is PRIME with cnt==0.
    sample = 8'd56;
    run    = 1'b1;
    @(negedge clk);
    check("prime_state", {30'd0, fsm_state}, 32'd1);
    check("prime_mix_en", {31'd0, mix_en}, 32'd1);

    // Period 1: PRIME, nothing to play yet.
    run_period("p1_prime", 0, 0, 1'b0, -1, 0, 8'd0);
    check("run_state", {30'd0, fsm_state}, 32'd2);
    // Period 2: first RUN, sample 56. Period 3: 56 again, then switch to 0.
    run_period("p2_56", 56, DS ? 55 : 56, 1'b1, -1, 0, 8'd0);
    run_period("p3_56", 56, 56, 1'b1, 10, 1, 8'd0);
    // Period 4: duty 0, then request 255.
    run_period("p4_0", 0, DS ? 1 : 0, 1'b1, 200, 1, 8'd255);
    // Period 5: duty 255, then request 67.
    run_period("p5_255", 255, DS ? 254 : 255, 1'b1, 30, 1, 8'd67);
    // Period 6: 67 while sample moves to 190 at cnt 100 (must not disturb).
    run_period("p6_67", 67, 67, 1'b1, 100, 1, 8'd190);
    // Period 7: 190; run dropped at cnt 50 must still finish the period.
    run_period("p7_190", 190, 190, 1'b1, 50, 2, 8'd0);

    // Back in IDLE, with the final strobe for the latch at the boundary.
    check("stop_state", {30'd0, fsm_state}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_pwm", {31'd0, pwm_out}, 32'd0);
    check("stop_stb", {31'd0, sample_stb}, 32'd1);
    mix_seen  = 0;
    busy_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mix_en) mix_seen++;
      if (busy) busy_seen++;
    end
    check("idle_mix_en", mix_seen, 0);
    check("idle_busy", busy_seen, 0);

    // Restart, then reset asynchronously at cnt 120 of the first RUN period.
    sample = 8'd190;
    run    = 1'b1;
    @(negedge clk);
    run_period("p8_prime", 0, 0, 1'b0, -1, 0, 8'd0);
    repeat (120) @(negedge clk);
    check("pre_rst_state", {30'd0, fsm_state}, 32'd2);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    if (!DS) check("pre_rst_pwm", {31'd0, pwm_out}, 32'd1);
    nrst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    nrst = 1'b1;
    run  = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("after_async_rst");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
